sync_receiver: RTL and testbench

- Serial receive stage; sits directly downstream of the serial transmitter and consumes its line output.
- Frame format matches the transmitter:
  - idle high
  - start bit 0
  - 8 data bits, LSB first
  - even-parity bit (XOR of the 8 data bits)
  - line high for at least one bit period (stop)
- Recovers the byte, checks parity and stop bit, and presents the result with a one-cycle valid strobe to the downstream logic.

---
 rtl/sync_receiver_if.sv | 13 +
 rtl/sync_receiver.sv | 139 +++++++++++++
 tb/tb_sync_receiver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sync_receiver_if.sv
// Receive-side result bus of sync_receiver: recovered byte, strobe, error flags, busy.
interface sync_receiver_if;
  logic [7:0] Data;
  logic       Valid;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       Busy;

  // Valid is a one-cycle strobe with no ready: the consumer must take Data
  // and the flags in the cycle Valid is high; they then hold until the next strobe.
  modport master (output Data, Valid, PARITY_ERR, FRAME_ERR, Busy);
  modport slave  (input  Data, Valid, PARITY_ERR, FRAME_ERR, Busy);
endinterface

// File: rtl/sync_receiver.sv
// Serial frame receiver (start, 8 data LSB first, optional even parity, stop).
// Optional build macro RX_MAJORITY_VOTE_EN: 3-sample majority vote per bit.
module sync_receiver #(
  parameter int CLKS_PER_BIT = 2606,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             IN_ser,
  sync_receiver_if.master  bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] target;
  logic [CW-1:0] next_cnt;
  logic          at_nominal;
  logic          decide;
  logic          bit_val;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rx_par;
  logic          stop_bit;

  assign target     = (state == S_START) ? HALF_CNT : FULL_CNT;
  assign at_nominal = (cnt == target);
  // The counter wraps at each nominal sample point so bit phase never drifts.
  assign next_cnt   = at_nominal ? '0 : cnt + CW'(1);
  assign bus.Busy   = (state != S_IDLE);
  assign state_dbg  = state;

`ifdef RX_MAJORITY_VOTE_EN
  logic v0, v1, vote_due, in_frame;

  assign in_frame = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
  assign decide   = vote_due;
  assign bit_val  = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      v0       <= 1'b1;
      v1       <= 1'b1;
      vote_due <= 1'b0;
    end else begin
      if (cnt == target - CW'(1)) v0 <= rx_s;
      if (at_nominal)             v1 <= rx_s;
      vote_due <= in_frame && at_nominal;
    end
  end
`else
  assign decide  = at_nominal;
  assign bit_val = rx_s;
`endif

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      rx_d           <= 1'b1;
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      rx_par         <= 1'b0;
      stop_bit       <= 1'b1;
      bus.Data       <= '0;
      bus.Valid      <= 1'b0;
      bus.PARITY_ERR <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
    end else begin
      rx_m      <= IN_ser;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      bus.Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (rx_d && !rx_s) state <= S_START;
        end
        S_START: begin
          cnt <= next_cnt;
          if (decide) begin
            idx   <= '0;
            state <= bit_val ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          cnt <= next_cnt;
          if (decide) begin
            shreg[idx] <= bit_val;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          cnt <= next_cnt;
          if (decide) begin
            rx_par <= bit_val;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          cnt <= next_cnt;
          if (decide) begin
            stop_bit <= bit_val;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          cnt            <= '0;
          bus.Data       <= shreg;
          bus.PARITY_ERR <= PARITY_EN ? ((^shreg) ^ rx_par) : 1'b0;
          bus.FRAME_ERR  <= ~stop_bit;
          bus.Valid      <= 1'b1;
          // A low stop bit may be a break; wait for the line to go high first.
          state          <= stop_bit ? S_IDLE : S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_receiver.sv
// Self-checking bench for sync_receiver: frame driver, expected-result queue, monitor.
module tb_sync_receiver;
  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       ser;
  logic [2:0] state_dbg;

  sync_receiver_if bus ();

  sync_receiver #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
    .CLK       (clk),
    .CLR_N     (rst_n),
    .IN_ser    (ser),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_pushed     = 0;
  int n_valid      = 0;

  // {busy_at_valid, frame_err, parity_err, data}
  logic [10:0] exp_q[$];
  logic [9:0]  last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic bit_period(input logic v, input logic spike);
    ser = v;
    repeat (8) @(negedge clk);
    if (spike) ser = ~v;
    @(negedge clk);
    ser = v;
    repeat (CPB - 9) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int stop_len, input int idle_len, input int spike_bit);
    exp_q.push_back({~stop, ~stop, (^d) ^ par, d});
    n_pushed++;
    bit_period(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i], (spike_bit == i));
    bit_period(par, 1'b0);
    ser = stop;
    repeat (stop_len) @(negedge clk);
    ser = 1'b1;
    repeat (idle_len) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = '0;
      check("reset_out", 32'({bus.Valid, bus.Busy, bus.FRAME_ERR, bus.PARITY_ERR, bus.Data}), 32'd0);
      check("reset_state", 32'(state_dbg), 32'd0);
    end else if (bus.Valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(bus.Valid), 32'd0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("data", 32'(bus.Data), 32'(e[7:0]));
        check("parity_err", 32'(bus.PARITY_ERR), 32'(e[8]));
        check("frame_err", 32'(bus.FRAME_ERR), 32'(e[9]));
        check("busy_after_done", 32'(bus.Busy), 32'(e[10]));
      end
      last_out = {bus.FRAME_ERR, bus.PARITY_ERR, bus.Data};
    end else begin
      check("held_out", 32'({bus.FRAME_ERR, bus.PARITY_ERR, bus.Data}), 32'(last_out));
    end
  end

  initial begin
    int busy_cycles;
    int exp_busy;
    logic [7:0] rd;
    logic       rp;
    ser   = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // nominal frame, correct parity
    send_frame(8'hA5, 1'b0, 1'b1, CPB, 2 * CPB, -1);
    // wrong parity
    send_frame(8'h01, 1'b0, 1'b1, CPB, 2 * CPB, -1);
    // break: stop held low three bit periods, then a clean frame
    send_frame(8'hFF, 1'b0, 1'b0, 3 * CPB, 2 * CPB, -1);
    send_frame(8'h3C, 1'b0, 1'b1, CPB, 2 * CPB, -1);

    // short low glitch on an idle line
    busy_cycles = 0;
    ser = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.Busy) busy_cycles++;
    end
    ser = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (bus.Busy) busy_cycles++;
    end
`ifdef RX_MAJORITY_VOTE_EN
    exp_busy = 9;
`else
    exp_busy = 8;
`endif
    check("glitch_busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    check("glitch_state_idle", 32'(state_dbg), 32'd0);

    // back-to-back: next start edge directly after one stop period
    send_frame(8'h55, 1'b0, 1'b1, CPB, 0, -1);
    send_frame(8'hAA, 1'b0, 1'b1, CPB, 2 * CPB, -1);

    // reset in data bit 4 of 0x77, then a fresh frame
    bit_period(1'b0, 1'b0);
    rd = 8'h77;
    for (int i = 0; i < 4; i++) bit_period(rd[i], 1'b0);
    ser = rd[4];
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    ser = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1, CPB, 2 * CPB, -1);

    // random bytes, parity randomly correct or wrong
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      rp = (^rd) ^ 1'($urandom_range(0, 1));
      send_frame(rd, rp, 1'b1, CPB, $urandom_range(0, 2 * CPB), -1);
    end

`ifdef RX_MAJORITY_VOTE_EN
    // single-clock inverted spike at a data-bit centre is voted out
    send_frame(8'h5A, 1'b0, 1'b1, CPB, 2 * CPB, 3);
`endif

    for (int i = 0; i < 4000 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    check("valid_count", 32'(n_valid), 32'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
